instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, single-entry
// instruction buffer toward the core, redirect with stale-response kill.
module instr_fetch #(
   parameter int                    REGWIDTH = 32,
   parameter logic [REGWIDTH-1:0]   RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [REGWIDTH-1:0] imem_addr,
   input  logic                imem_rvalid,
   input  logic [REGWIDTH-1:0] imem_rdata,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [REGWIDTH-1:0] inst,
   output logic [REGWIDTH-1:0] pc_out,
   input  logic                redirect,
   input  logic [REGWIDTH-1:0] redirect_pc,
   output logic                misaligned
);

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      HOLD
   } state_t;

   localparam logic [REGWIDTH-1:0] PC_STEP = REGWIDTH'(4);

   state_t              state_q, state_d;
   logic [REGWIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                kill_q, kill_d;
   logic                inst_valid_d;
   logic [REGWIDTH-1:0] inst_d, pc_out_d;
   logic                misaligned_d;

   // Reset gates the request so nothing leaks out while rst is low.
   assign imem_req  = rst && (state_q == FETCH) && !redirect;
   assign imem_addr = fetch_pc_q;

   always_comb begin
      // NOTE: every signal gets a default before any branch, otherwise a
      // path that skips an assignment infers a latch.
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      kill_d       = kill_q;
      inst_valid_d = inst_valid;
      inst_d       = inst;
      pc_out_d     = pc_out;
      misaligned_d = 1'b0;

      if (redirect) begin
         fetch_pc_d   = {redirect_pc[REGWIDTH-1:2], 2'b00};
         inst_valid_d = 1'b0;
         misaligned_d = |redirect_pc[1:0];
         if (state_q == WAIT && !imem_rvalid) begin
            // The in-flight response still has to come back; discard it then.
            kill_d = 1'b1;
         end else begin
            kill_d  = 1'b0;
            state_d = FETCH;
         end
      end else begin
         unique case (state_q)
            FETCH: state_d = WAIT;
            WAIT: begin
               if (imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = FETCH;
                  end else begin
                     inst_d       = imem_rdata;
                     pc_out_d     = fetch_pc_q;
                     inst_valid_d = 1'b1;
                     fetch_pc_d   = fetch_pc_q + PC_STEP;
                     state_d      = HOLD;
                  end
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  inst_valid_d = 1'b0;
                  state_d      = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         kill_q     <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= '0;
         pc_out     <= '0;
         misaligned <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         kill_q     <= kill_d;
         inst_valid <= inst_valid_d;
         inst       <= inst_d;
         pc_out     <= pc_out_d;
         misaligned <= misaligned_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked
// against a transaction-level model of fetch order, buffering and redirects.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_rvalid, inst_valid, inst_ready, redirect, misaligned;
   logic [31:0] imem_addr, imem_rdata, inst, pc_out, redirect_pc;

   always #5 clk = ~clk;

   instr_fetch #(.REGWIDTH(32), .RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .pc_out     (pc_out),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .misaligned (misaligned)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   // memory environment
   bit mem_out, mem_stale, const_data, rand_en, late_junk;
   int mem_resp, fixed_lat;

   // reference model: next address to be delivered, buffered word, expectations
   logic [31:0] exp_pc, exp_inst;
   bit          exp_valid, exp_fetch, exp_mis;

   // per-step observations for directed checks
   bit          s_req, s_valid, s_mis;
   logic [31:0] s_addr;
   int          hs_cyc[$];
   logic [31:0] hs_pc[$];
   int          idle, max_idle;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic        rv, n_valid, n_fetch, fresh;
      logic [31:0] rd;
      int          lat;
      if (rand_en) begin
         redirect   = ($urandom_range(0, 15) == 0);
         inst_ready = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0:       redirect_pc = $urandom();
            1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2:       redirect_pc = 32'($urandom_range(0, 255));
            default: redirect_pc = $urandom() & 32'hFFFF_FFFC;
         endcase
      end
      rv = 1'b0;
      rd = $urandom();
      if (mem_out && mem_resp == cyc) begin
         rv = 1'b1;
         if (const_data) rd = 32'h0050_0093;
      end else if (rand_en && !mem_out && $urandom_range(0, 9) == 0) begin
         rv = 1'b1;
      end
      if (late_junk) begin
         rv = 1'b1;
         rd = 32'hDEAD_BEEF;
      end
      imem_rvalid = rv;
      imem_rdata  = rd;
      #1;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = inst_valid;
      s_mis   = misaligned;

      check("misaligned", misaligned, exp_mis);
      check("inst_valid", inst_valid, exp_valid);
      if (exp_valid) begin
         check("pc_out", pc_out, exp_pc);
         check("inst", inst, exp_inst);
      end
      if (redirect || exp_valid || mem_out) check("req_idle", imem_req, 1'b0);
      else if (exp_fetch)                   check("req_fetch", imem_req, 1'b1);
      if (imem_req) check("imem_addr", imem_addr, exp_pc);

      fresh   = !redirect && rv && mem_out && !mem_stale;
      n_valid = (!redirect && exp_valid && !inst_ready) || fresh;
      n_fetch = (redirect && !(mem_out && !rv))
             || (!redirect && exp_valid && inst_ready)
             || (!redirect && rv && mem_out && mem_stale);
      if (fresh) exp_inst = rd;
      if (!redirect && exp_valid && inst_ready) begin
         hs_cyc.push_back(cyc);
         hs_pc.push_back(exp_pc);
         idle = 0;
      end else if (redirect) begin
         idle = 0;
      end else begin
         idle++;
      end
      if (idle > max_idle) max_idle = idle;
      if (redirect) begin
         exp_pc = {redirect_pc[31:2], 2'b00};
         if (mem_out && !rv) mem_stale = 1'b1;
      end else if (exp_valid && inst_ready) begin
         exp_pc = exp_pc + 32'd4;
      end
      exp_valid = n_valid;
      exp_fetch = n_fetch;
      exp_mis   = redirect && (redirect_pc[1:0] != 2'b00);
      if (rv && mem_out) begin
         mem_out   = 1'b0;
         mem_stale = 1'b0;
      end
      if (imem_req) begin
         lat       = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
         mem_out   = 1'b1;
         mem_stale = 1'b0;
         mem_resp  = cyc + lat;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic apply_reset(input int hold);
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      late_junk   = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_misaligned", misaligned, 1'b0);
      check("rst_imem_req", imem_req, 1'b0);
      repeat (hold) @(negedge clk);
      rst       = 1'b1;
      mem_out   = 1'b0;
      mem_stale = 1'b0;
      exp_pc    = RESET_PC;
      exp_inst  = 32'h0;
      exp_valid = 1'b0;
      exp_fetch = 1'b1;
      exp_mis   = 1'b0;
      cyc       = 0;
      idle      = 0;
      hs_cyc.delete();
      hs_pc.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      rand_en     = 1'b0;
      const_data  = 1'b1;
      fixed_lat   = 1;
      max_idle    = 0;
      @(negedge clk);
      apply_reset(2);

      // steady state: 1-cycle memory, core always ready
      repeat (10) step();
      check("tp_count", 32'(hs_cyc.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("tp_cycle", 32'(hs_cyc[i]), 32'(2 + 3 * i));
         check("tp_pc", hs_pc[i], 32'(4 * i));
      end

      // core stalls five cycles with an instruction buffered
      const_data = 1'b0;
      inst_ready = 1'b0;
      guard = 0;
      do begin step(); guard++; end while (!s_valid && guard < 20);
      check("stall_valid_seen", s_valid, 1'b1);
      repeat (5) step();
      inst_ready = 1'b1;
      step();
      step();
      check("stall_resume_req", s_req, 1'b1);

      // redirect while waiting, response comes back later and is dropped
      fixed_lat = 3;
      guard = 0;
      do begin step(); guard++; end while (!s_req && guard < 20);
      check("wait_req_seen", s_req, 1'b1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      fixed_lat   = 2;
      step();
      redirect = 1'b0;
      guard = 0;
      do begin step(); guard++; end while (!s_req && guard < 20);
      check("kill_req_seen", s_req, 1'b1);
      check("kill_req_addr", s_addr, 32'h0000_0100);

      // redirect in the same cycle as the response
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      step();
      check("same_cyc_req", s_req, 1'b1);
      check("same_cyc_addr", s_addr, 32'h0000_0200);

      // misaligned target, then fetch across the top of the address space
      fixed_lat   = 1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect = 1'b0;
      step();
      check("mis_pulse", s_mis, 1'b1);
      step();
      check("mis_clear", s_mis, 1'b0);
      guard = 0;
      while (!s_req && guard < 20) begin step(); guard++; end
      check("mis_req_seen", s_req, 1'b1);
      check("mis_req_addr", s_addr, 32'h0000_0100);
      hs_pc.delete();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      guard = 0;
      while (hs_pc.size() < 2 && guard < 30) begin step(); guard++; end
      check("wrap_count", 32'(hs_pc.size()), 32'd2);
      check("wrap_top", hs_pc[0], 32'hFFFF_FFFC);
      check("wrap_zero", hs_pc[1], 32'h0000_0000);

      // reset in the middle of a wait, late response after release
      fixed_lat = 3;
      guard = 0;
      do begin step(); guard++; end while (!s_req && guard < 20);
      step();
      apply_reset(2);
      fixed_lat = 1;
      late_junk = 1'b1;
      step();
      late_junk = 1'b0;
      check("late_req", s_req, 1'b1);
      check("late_addr", s_addr, RESET_PC);
      guard = 0;
      while (hs_pc.size() < 1 && guard < 20) begin step(); guard++; end
      check("late_first_pc", hs_pc[0], RESET_PC);

      // random traffic
      rand_en   = 1'b1;
      fixed_lat = 0;
      max_idle  = 0;
      hs_pc.delete();
      repeat (3000) step();
      rand_en  = 1'b0;
      redirect = 1'b0;
      check("rand_no_stall", max_idle > 40, 1'b0);
      check("rand_progress", hs_pc.size() > 100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
